// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink path: one-hot rate codes, FSM state
// encodings and the rate legality check used by every consumer of the code.
package blink_pkg;

    localparam int RATE_W = 4;

    typedef logic [RATE_W-1:0] rate_t;

    localparam rate_t RATE_SLOW = 4'b0001;
    localparam rate_t RATE_MID  = 4'b0010;
    localparam rate_t RATE_FAST = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_e;

    function automatic logic rate_legal(input rate_t rate);
        return (rate == RATE_SLOW) || (rate == RATE_MID) || (rate == RATE_FAST);
    endfunction

endpackage

// File: rtl/blink_rate_decode.sv
// Maps a one-hot rate code to its legality and half-period in ticks.
// Illegal codes report the slow half-period so callers always get a bound.
module blink_rate_decode
    import blink_pkg::*;
#(
    parameter int BASE_HALF = 8,
    parameter int CNT_W     = 4
) (
    input  rate_t              rate_i,
    output logic               legal_o,
    output logic [CNT_W-1:0]   half_period_o
);

    localparam logic [CNT_W-1:0] HALF_SLOW = CNT_W'(BASE_HALF);
    localparam logic [CNT_W-1:0] HALF_MID  = CNT_W'(BASE_HALF / 2);
    localparam logic [CNT_W-1:0] HALF_FAST = CNT_W'(BASE_HALF / 4);

    always_comb begin
        legal_o = rate_legal(rate_i);
        case (rate_i)
            RATE_MID:  half_period_o = HALF_MID;
            RATE_FAST: half_period_o = HALF_FAST;
            default:   half_period_o = HALF_SLOW;
        endcase
    end

endmodule

// File: rtl/dffr.sv
// Team flop: W-bit register with synchronous active-high reset to RST_VAL.
module dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: non-blocking so every flop in the design samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/blink_generator.sv
// 50% duty LED blinker driven by a one-hot rate code and a slow tick.
// Rate changes are staged in pend_rate and take effect only at phase edges.
module blink_generator
    import blink_pkg::*;
#(
    parameter int BASE_HALF = 8,
    parameter int CNT_W     = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  tick,
    input  logic  enable,
    input  rate_t rate,
    output logic  led,
    output logic  blink_pulse,
    output logic  rate_err,
    output rate_t active_rate
);

    localparam logic [CNT_W-1:0] HALF_SLOW = CNT_W'(BASE_HALF);

    logic [1:0]       state_bits_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             pulse_q, pulse_d;
    logic             err_q, err_d;
    rate_t            pend_q, pend_d;
    rate_t            active_q, active_d;

    logic             in_legal;
    logic [CNT_W-1:0] in_half;
    logic             act_legal;
    logic [CNT_W-1:0] act_half;
    logic [CNT_W-1:0] cnt_last;
    logic             phase_done;

    blink_rate_decode #(
        .BASE_HALF (BASE_HALF),
        .CNT_W     (CNT_W)
    ) u_in_decode (
        .rate_i        (rate),
        .legal_o       (in_legal),
        .half_period_o (in_half)
    );

    blink_rate_decode #(
        .BASE_HALF (BASE_HALF),
        .CNT_W     (CNT_W)
    ) u_act_decode (
        .rate_i        (active_q),
        .legal_o       (act_legal),
        .half_period_o (act_half)
    );

    // State register and datapath flops.
    dffr #(.W(2), .RST_VAL(ST_IDLE)) u_state_ff (
        .clk (clk), .rst (rst), .d (state_d), .q (state_bits_q)
    );
    dffr #(.W(CNT_W), .RST_VAL('0)) u_cnt_ff (
        .clk (clk), .rst (rst), .d (cnt_d), .q (cnt_q)
    );
    dffr #(.W(1), .RST_VAL(1'b0)) u_led_ff (
        .clk (clk), .rst (rst), .d (led_d), .q (led_q)
    );
    dffr #(.W(1), .RST_VAL(1'b0)) u_pulse_ff (
        .clk (clk), .rst (rst), .d (pulse_d), .q (pulse_q)
    );
    dffr #(.W(1), .RST_VAL(1'b0)) u_err_ff (
        .clk (clk), .rst (rst), .d (err_d), .q (err_q)
    );
    dffr #(.W(RATE_W), .RST_VAL(RATE_SLOW)) u_pend_ff (
        .clk (clk), .rst (rst), .d (pend_d), .q (pend_q)
    );
    dffr #(.W(RATE_W), .RST_VAL(RATE_SLOW)) u_active_ff (
        .clk (clk), .rst (rst), .d (active_d), .q (active_q)
    );

    assign state_q = state_e'(state_bits_q);

    // active_q is legal by construction; the fallback keeps the bound sane anyway.
    // Subtracting at CNT_W bits also covers BASE_HALF == 2**CNT_W.
    assign cnt_last   = (act_legal ? act_half : HALF_SLOW) - CNT_W'(1);
    assign phase_done = tick && (cnt_q == cnt_last);

    // Next-state logic for every register.
    always_comb begin
        // NOTE: defaults first so no path leaves a _d unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        pulse_d  = 1'b0;
        active_d = active_q;
        pend_d   = in_legal ? rate : pend_q;
        err_d    = ~in_legal;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            led_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ON;
                    cnt_d    = '0;
                    led_d    = 1'b1;
                    pulse_d  = 1'b1;
                    active_d = pend_q;
                end
                ST_ON: begin
                    if (phase_done) begin
                        state_d  = ST_OFF;
                        cnt_d    = '0;
                        led_d    = 1'b0;
                        active_d = pend_q;
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (phase_done) begin
                        state_d  = ST_ON;
                        cnt_d    = '0;
                        led_d    = 1'b1;
                        pulse_d  = 1'b1;
                        active_d = pend_q;
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops so the LED pin never sees comb glitches.
    always_comb begin
        led         = led_q;
        blink_pulse = pulse_q;
        rate_err    = err_q;
        active_rate = active_q;
    end

endmodule

// File: tb/tb_blink_generator.sv
// Directed bench for blink_generator with BASE_HALF=8: phase lengths, rate
// staging, illegal codes, sparse ticks, enable drop and synchronous reset.
module tb_blink_generator;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       enable;
    logic [3:0] rate;
    logic       led;
    logic       blink_pulse;
    logic       rate_err;
    logic [3:0] active_rate;

    int checks;
    int failures;

    blink_generator #(
        .BASE_HALF (8),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .enable      (enable),
        .rate        (rate),
        .led         (led),
        .blink_pulse (blink_pulse),
        .rate_err    (rate_err),
        .active_rate (active_rate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        tick   = 1'b1;
        rate   = 4'b0001;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        tick   = 1'b1;
        rate   = 4'b1000;
        step();
        step();
        checks += 4;
        if (led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", led); end
        if (blink_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", blink_pulse); end
        if (rate_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rate_err); end
        if (active_rate !== 4'b0001) begin failures++; $display("FAIL reset_active got=%b exp=0001", active_rate); end
        rst = 1'b0;
    endtask

    task automatic test_blink_basic();
        logic exp_led, exp_pulse;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_led   = (((k - 1) / 8) % 2) == 0;
            exp_pulse = ((k - 1) % 16) == 0;
            checks += 3;
            if (led !== exp_led) begin failures++; $display("FAIL basic_led cyc=%0d got=%b exp=%b", k, led, exp_led); end
            if (blink_pulse !== exp_pulse) begin failures++; $display("FAIL basic_pulse cyc=%0d got=%b exp=%b", k, blink_pulse, exp_pulse); end
            if (active_rate !== 4'b0001) begin failures++; $display("FAIL basic_active cyc=%0d got=%b exp=0001", k, active_rate); end
        end
    endtask

    task automatic test_rate_switch();
        logic       exp_led, exp_pulse;
        logic [3:0] exp_act;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 8) begin
                exp_led   = 1'b1;
                exp_pulse = (k == 1);
                exp_act   = 4'b0001;
            end else begin
                exp_led   = (((k - 9) / 2) % 2) == 1;
                exp_pulse = ((k - 9) % 4) == 2;
                exp_act   = 4'b0100;
            end
            checks += 3;
            if (led !== exp_led) begin failures++; $display("FAIL switch_led cyc=%0d got=%b exp=%b", k, led, exp_led); end
            if (blink_pulse !== exp_pulse) begin failures++; $display("FAIL switch_pulse cyc=%0d got=%b exp=%b", k, blink_pulse, exp_pulse); end
            if (active_rate !== exp_act) begin failures++; $display("FAIL switch_active cyc=%0d got=%b exp=%b", k, active_rate, exp_act); end
            if (k == 3) rate = 4'b0100;
        end
    endtask

    task automatic test_illegal_rate();
        logic       exp_led, exp_pulse, exp_err;
        logic [3:0] exp_act;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_err = (k >= 3) && (k <= 20);
            if (k <= 24) begin
                exp_led   = (((k - 1) / 8) % 2) == 0;
                exp_pulse = ((k - 1) % 16) == 0;
                exp_act   = 4'b0001;
            end else begin
                exp_led   = (((k - 25) / 4) % 2) == 1;
                exp_pulse = ((k - 25) % 8) == 4;
                exp_act   = 4'b0010;
            end
            checks += 4;
            if (rate_err !== exp_err) begin failures++; $display("FAIL illegal_err cyc=%0d got=%b exp=%b", k, rate_err, exp_err); end
            if (led !== exp_led) begin failures++; $display("FAIL illegal_led cyc=%0d got=%b exp=%b", k, led, exp_led); end
            if (blink_pulse !== exp_pulse) begin failures++; $display("FAIL illegal_pulse cyc=%0d got=%b exp=%b", k, blink_pulse, exp_pulse); end
            if (active_rate !== exp_act) begin failures++; $display("FAIL illegal_active cyc=%0d got=%b exp=%b", k, active_rate, exp_act); end
            if (k == 2)  rate = 4'b0110;
            if (k == 3)  rate = 4'b0000;
            if (k == 20) rate = 4'b0010;
        end
    endtask

    task automatic test_sparse_tick();
        logic exp_led, exp_pulse;
        do_reset();
        rate = 4'b0010;
        step();
        enable = 1'b1;
        for (int j = 1; j <= 48; j++) begin
            tick = (j % 3 == 0);
            step();
            exp_led   = (j <= 11) ? 1'b1 : ((((j - 12) / 12) % 2) == 1);
            exp_pulse = (j == 1) || (j == 24) || (j == 48);
            checks += 3;
            if (led !== exp_led) begin failures++; $display("FAIL tick_led cyc=%0d got=%b exp=%b", j, led, exp_led); end
            if (blink_pulse !== exp_pulse) begin failures++; $display("FAIL tick_pulse cyc=%0d got=%b exp=%b", j, blink_pulse, exp_pulse); end
            if (active_rate !== 4'b0010) begin failures++; $display("FAIL tick_active cyc=%0d got=%b exp=0010", j, active_rate); end
        end
        tick = 1'b1;
    endtask

    task automatic test_enable_drop();
        logic exp_led;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_led = (k <= 8);
            checks++;
            if (led !== exp_led) begin failures++; $display("FAIL drop_led cyc=%0d got=%b exp=%b", k, led, exp_led); end
            if (k == 12) rate = 4'b0100;
            if (k == 16) enable = 1'b0;
        end
        step();
        checks += 3;
        if (led !== 1'b0) begin failures++; $display("FAIL drop_idle_led got=%b exp=0", led); end
        if (blink_pulse !== 1'b0) begin failures++; $display("FAIL drop_idle_pulse got=%b exp=0", blink_pulse); end
        if (active_rate !== 4'b0001) begin failures++; $display("FAIL drop_idle_active got=%b exp=0001", active_rate); end
        step();
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL drop_idle2_led got=%b exp=0", led); end
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks += 3;
            if (led !== ((k <= 2) || (k == 5))) begin failures++; $display("FAIL reen_led cyc=%0d got=%b", k, led); end
            if (blink_pulse !== ((k == 1) || (k == 5))) begin failures++; $display("FAIL reen_pulse cyc=%0d got=%b", k, blink_pulse); end
            if (active_rate !== 4'b0100) begin failures++; $display("FAIL reen_active cyc=%0d got=%b exp=0100", k, active_rate); end
        end
    endtask

    task automatic test_reset_mid_off();
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 10) rate = 4'b0100;
            if (k == 12) rate = 4'b1000;
        end
        checks += 2;
        if (rate_err !== 1'b1) begin failures++; $display("FAIL midoff_err got=%b exp=1", rate_err); end
        if (led !== 1'b0) begin failures++; $display("FAIL midoff_led got=%b exp=0", led); end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks += 4;
            if (led !== 1'b0) begin failures++; $display("FAIL rsthold_led cyc=%0d got=%b exp=0", k, led); end
            if (blink_pulse !== 1'b0) begin failures++; $display("FAIL rsthold_pulse cyc=%0d got=%b exp=0", k, blink_pulse); end
            if (rate_err !== 1'b0) begin failures++; $display("FAIL rsthold_err cyc=%0d got=%b exp=0", k, rate_err); end
            if (active_rate !== 4'b0001) begin failures++; $display("FAIL rsthold_active cyc=%0d got=%b exp=0001", k, active_rate); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks += 4;
            if (led !== (k <= 8)) begin failures++; $display("FAIL rstrel_led cyc=%0d got=%b", k, led); end
            if (blink_pulse !== (k == 1)) begin failures++; $display("FAIL rstrel_pulse cyc=%0d got=%b", k, blink_pulse); end
            if (rate_err !== 1'b1) begin failures++; $display("FAIL rstrel_err cyc=%0d got=%b exp=1", k, rate_err); end
            if (active_rate !== 4'b0001) begin failures++; $display("FAIL rstrel_active cyc=%0d got=%b exp=0001", k, active_rate); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        enable   = 1'b0;
        rate     = 4'b0001;
        test_reset();
        test_blink_basic();
        test_rate_switch();
        test_illegal_rate();
        test_sparse_tick();
        test_enable_drop();
        test_reset_mid_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
